// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM data-port arbiter.
// Address range checking is built in with SRAM_ARB_RANGE_CHECK_EN.
package sram_arb_pkg;

  localparam int OUTSTANDING_DEPTH_DEF = 2;

  typedef logic mid_t;

  typedef struct packed {
    mid_t id;
    logic err;
  } fifo_entry_t;

  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] lim
  );
    return (addr >= base) && (addr < lim);
  endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order FIFO of master IDs for transactions awaiting a response.
// Pushes when full and pops when empty are dropped.
module sram_arb_idfifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEPTH_DEF,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  fifo_entry_t   wdata,
  input  logic          pop,
  output fifo_entry_t   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop) rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Round-robin OBI arbiter of two masters onto the SRAM data port.
// Define SRAM_ARB_RANGE_CHECK_EN to answer out-of-range requests locally.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR    = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR     = 32'h8000_C000,
  parameter int          OUTSTANDING_DEPTH = OUTSTANDING_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        sram_d_req_o,
  output logic        sram_d_we_o,
  output logic [31:0] sram_d_addr_o,
  output logic [31:0] sram_d_wdata_o,
  output logic [3:0]  sram_d_be_o,
  input  logic        sram_d_gnt_i,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,
  output logic        illegal_memory_o
);

  localparam int CW = $clog2(OUTSTANDING_DEPTH + 1);

  logic          live_q;
  logic          live;
  logic [1:0]    req;
  logic [1:0]    legal;
  logic [1:0]    ok;
  logic          we [2];
  logic [31:0]   addr [2];
  logic [31:0]   wdata [2];
  logic [3:0]    be [2];
  logic          any;
  mid_t          sel;
  mid_t          last_q;
  logic          fwd;
  logic          hs;
  logic          ill;
  logic          granted;
  logic          pop;
  logic          err_q;
  mid_t          err_id_q;
  logic          rsp_v;
  mid_t          rsp_id;
  logic          rsp_err;
  logic [31:0]   rsp_data;
  fifo_entry_t   push_e;
  fifo_entry_t   head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          unused_cnt;

  assign req      = {m1_req_i, m0_req_i};
  assign we[0]    = m0_we_i;
  assign we[1]    = m1_we_i;
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign wdata[0] = m0_wdata_i;
  assign wdata[1] = m1_wdata_i;
  assign be[0]    = m0_be_i;
  assign be[1]    = m1_be_i;

  // Outputs stay quiet during reset and for one cycle after it.
  always_ff @(posedge clk_i) begin
    live_q <= rst_ni;
  end

  assign live = rst_ni & live_q;

`ifdef SRAM_ARB_RANGE_CHECK_EN
  assign legal[0] = in_range(m0_addr_i,
                             SRAM_BASE_ADDR,
                             SRAM_END_ADDR);
  assign legal[1] = in_range(m1_addr_i,
                             SRAM_BASE_ADDR,
                             SRAM_END_ADDR);
  assign rsp_err  = err_q | (pop & head.err);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      err_q    <= ill;
      err_id_q <= sel;
    end
  end
`else
  logic unused_range;

  assign legal        = 2'b11;
  assign rsp_err      = 1'b0;
  assign err_q        = 1'b0;
  assign err_id_q     = '0;
  assign unused_range = ^{SRAM_BASE_ADDR,
                          SRAM_END_ADDR,
                          head.err};
`endif

  // Illegal requests only go once nothing else is in flight.
  assign ok[0] = req[0] & ~err_q &
                 (legal[0] ? ~full : empty);
  assign ok[1] = req[1] & ~err_q &
                 (legal[1] ? ~full : empty);

  always_comb begin
    any = 1'b1;
    sel = 1'b0;
    unique case (1'b1)
      ok == 2'b11: sel = ~last_q;
      ok == 2'b01: sel = 1'b0;
      ok == 2'b10: sel = 1'b1;
      default:     any = 1'b0;
    endcase
  end

  assign fwd     = live & any & legal[sel];
  assign ill     = live & any & ~legal[sel];
  assign hs      = fwd & sram_d_gnt_i;
  assign granted = hs | ill;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= 1'b1;
    else if (granted) last_q <= sel;
  end

  assign sram_d_req_o     = fwd;
  assign sram_d_we_o      = fwd & we[sel];
  assign sram_d_addr_o    = fwd ? addr[sel] : '0;
  assign sram_d_wdata_o   = fwd ? wdata[sel] : '0;
  assign sram_d_be_o      = fwd ? be[sel] : '0;
  assign m0_gnt_o         = granted & ~sel;
  assign m1_gnt_o         = granted & sel;
  assign illegal_memory_o = ill;

  assign push_e = '{id: sel, err: 1'b0};
  assign pop    = live & sram_d_rvalid_i & ~empty;

  sram_arb_idfifo #(
    .DEPTH(OUTSTANDING_DEPTH)
  ) u_idfifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (hs),
    .wdata (push_e),
    .pop   (pop),
    .rdata (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign unused_cnt = ^cnt;

  assign rsp_v    = live & (err_q | pop);
  assign rsp_id   = err_q ? err_id_q : head.id;
  assign rsp_data = err_q ? '0 : sram_d_rdata_i;

  assign m0_rvalid_o = rsp_v & ~rsp_id;
  assign m1_rvalid_o = rsp_v & rsp_id;
  assign m0_err_o    = m0_rvalid_o & rsp_err;
  assign m1_err_o    = m1_rvalid_o & rsp_err;
  assign m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Randomized bench for sram_d_arbiter against a queue-based model.
// Define SRAM_ARB_RANGE_CHECK_EN to also exercise the range check.
module tb_sram_d_arbiter;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIM   = 32'h8000_C000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic        gnt_in;
  logic        rv_in;
  logic [31:0] rdata_in;

  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        ill_mem;

  int   checks = 0;
  int   errors = 0;

  int   q[$];
  int   last = 1;
  int   errp = -1;
  bit   prev_rst = 1'b0;
  logic [1:0]  g_mask;

  logic [1:0]  o_gnt, o_rv, o_err;
  logic [31:0] o_rd0;
  logic        o_sreq, o_ill;

  always #5 clk = ~clk;

  sram_d_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .m0_req_i        (req[0]),
    .m0_we_i         (we[0]),
    .m0_addr_i       (addr[0]),
    .m0_wdata_i      (wdata[0]),
    .m0_be_i         (be[0]),
    .m0_gnt_o        (m0_gnt),
    .m0_rvalid_o     (m0_rvalid),
    .m0_err_o        (m0_err),
    .m0_rdata_o      (m0_rdata),
    .m1_req_i        (req[1]),
    .m1_we_i         (we[1]),
    .m1_addr_i       (addr[1]),
    .m1_wdata_i      (wdata[1]),
    .m1_be_i         (be[1]),
    .m1_gnt_o        (m1_gnt),
    .m1_rvalid_o     (m1_rvalid),
    .m1_err_o        (m1_err),
    .m1_rdata_o      (m1_rdata),
    .sram_d_req_o    (s_req),
    .sram_d_we_o     (s_we),
    .sram_d_addr_o   (s_addr),
    .sram_d_wdata_o  (s_wdata),
    .sram_d_be_o     (s_be),
    .sram_d_gnt_i    (gnt_in),
    .sram_d_rvalid_i (rv_in),
    .sram_d_rdata_i  (rdata_in),
    .illegal_memory_o(ill_mem)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
`ifdef SRAM_ARB_RANGE_CHECK_EN
    return (a >= BASE) && (a < LIM);
`else
    return (a == a);
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return BASE - 32'd4;
      1:       return LIM;
      2:       return LIM - 32'd4;
      3:       return BASE;
      default: return BASE + ($urandom_range(0, 32'h2FFF) << 2);
    endcase
  endfunction

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit          live, fpop, hs, ill;
    bit          ok [2];
    int          w, rsp;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_rd [2];
    logic        e_sreq, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    #1;
    live = rst_n && prev_rst;
    w = -1; rsp = -1;
    fpop = 0; hs = 0; ill = 0;
    e_gnt = '0; e_rv = '0; e_err = '0;
    e_rd[0] = '0; e_rd[1] = '0;
    e_sreq = 0; e_we = 0;
    e_addr = '0; e_wd = '0; e_be = '0;
    if (live) begin
      for (int i = 0; i < 2; i++)
        ok[i] = req[i] && q.size() < DEPTH && errp < 0 &&
                (legal(addr[i]) || q.size() == 0);
      if (ok[0] && ok[1]) w = 1 - last;
      else if (ok[0]) w = 0;
      else if (ok[1]) w = 1;
      if (w >= 0) begin
        if (legal(addr[w])) begin
          e_sreq = 1;
          e_addr = addr[w];
          e_we = we[w];
          e_be = be[w];
          e_wd = wdata[w];
          hs = gnt_in;
          e_gnt[w] = gnt_in;
        end else begin
          ill = 1;
          e_gnt[w] = 1'b1;
        end
      end
      if (errp >= 0) begin
        rsp = errp;
        e_err[rsp] = 1'b1;
      end else if (rv_in && q.size() > 0) begin
        rsp = q[0];
        fpop = 1;
        e_rd[rsp] = rdata_in;
      end
      if (rsp >= 0) e_rv[rsp] = 1'b1;
    end
    o_gnt  = {m1_gnt, m0_gnt};
    o_rv   = {m1_rvalid, m0_rvalid};
    o_err  = {m1_err, m0_err};
    o_rd0  = m0_rdata;
    o_sreq = s_req;
    o_ill  = ill_mem;
    check("gnt", o_gnt, e_gnt);
    check("rvalid", o_rv, e_rv);
    check("err", o_err, e_err);
    check("rdata0", m0_rdata, e_rd[0]);
    check("rdata1", m1_rdata, e_rd[1]);
    check("sram_req", s_req, e_sreq);
    check("sram_addr", s_addr, e_addr);
    check("sram_we", s_we, e_we);
    check("sram_be", s_be, e_be);
    check("sram_wdata", s_wdata, e_wd);
    check("illegal", ill_mem, ill);
    g_mask = e_gnt;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      errp = -1;
      last = 1;
    end else if (live) begin
      if (fpop) void'(q.pop_front());
      if (hs) q.push_back(w);
      errp = ill ? w : -1;
      if (hs || ill) last = w;
    end
    prev_rst = rst_n;
    @(negedge clk);
  endtask

  task automatic idle();
    req = '0;
    gnt_in = 1'b1;
    rv_in = 1'b0;
    rdata_in = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b0;
      addr[i] = BASE;
      wdata[i] = '0;
      be[i] = 4'hF;
    end
    g_mask = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // both request together straight after reset
    req = 2'b11;
    addr[0] = 32'h8000_0010;
    addr[1] = 32'h8000_0100;
    we[1] = 1'b1;
    wdata[1] = 32'hA5A5_0001;
    cycle();
    check("a_m0_first", o_gnt, 2'b01);
    req[0] = 1'b0;
    cycle();
    check("a_m1_next", o_gnt, 2'b10);
    req = '0;
    rv_in = 1'b1;
    rdata_in = 32'hDEAD_BEEF;
    cycle();
    check("a_rv_m0", o_rv, 2'b01);
    check("a_rdata_m0", o_rd0, 32'hDEAD_BEEF);
    rdata_in = 32'h1234_5678;
    cycle();
    check("a_rv_m1", o_rv, 2'b10);

    // held requests alternate with a one-cycle SRAM
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      rdata_in = $urandom;
      cycle();
      check("b_alt", o_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req = '0;
    cycle();

    // outstanding limit; a pop does not free a slot the same cycle
    req = 2'b11;
    rv_in = 1'b0;
    cycle();
    check("c_g1", o_gnt, 2'b01);
    cycle();
    check("c_g2", o_gnt, 2'b10);
    cycle();
    check("c_full", o_gnt, 2'b00);
    rv_in = 1'b1;
    cycle();
    check("c_pop_same", o_gnt, 2'b00);
    check("c_pop_rv", o_rv, 2'b01);
    rv_in = 1'b0;
    cycle();
    check("c_g3", o_gnt, 2'b01);

    // reset with two in flight drops their responses
    rst_n = 1'b0;
    rv_in = 1'b1;
    cycle();
    check("d_rst_rv", o_rv, 2'b00);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("d_first", {o_gnt, o_rv}, 4'h0);
    cycle();
    check("d_rv_drop", o_rv, 2'b00);
    check("d_m0", o_gnt, 2'b01);
    req = '0;
    cycle();
    rv_in = 1'b0;

`ifdef SRAM_ARB_RANGE_CHECK_EN
    req = 2'b10;
    addr[1] = LIM;
    gnt_in = 1'b0;
    cycle();
    check("e_gnt", o_gnt, 2'b10);
    check("e_ill", o_ill, 1'b1);
    check("e_sreq", o_sreq, 1'b0);
    req = 2'b01;
    addr[0] = BASE;
    gnt_in = 1'b1;
    cycle();
    check("e_rv", o_rv, 2'b10);
    check("e_err", o_err, 2'b10);
    check("e_block", o_gnt, 2'b00);
    cycle();
    check("e_after", o_gnt, 2'b01);
    req = '0;
    rv_in = 1'b1;
    cycle();
    rv_in = 1'b0;
`endif

    // random traffic; requests are held until granted
    g_mask = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || g_mask[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          addr[i] = rand_addr();
          wdata[i] = $urandom;
          we[i] = $urandom_range(0, 1) == 1;
          be[i] = 4'($urandom_range(0, 15));
        end
      end
      gnt_in = ($urandom_range(0, 3) != 0);
      rv_in = $urandom_range(0, 1) == 1;
      rdata_in = $urandom;
      rst_n = !(k >= 200 && k < 203);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_d_arbiter.md
SRAM_D_ARBITER -- requirements
Module: sram_d_arbiter

Interface
REQ-001 SHALL have parameter SRAM_BASE_ADDR, default 32'h8000_0000, lowest legal byte address.
REQ-002 SHALL have parameter SRAM_END_ADDR, default 32'h8000_C000, first illegal byte address above SRAM.
REQ-003 SHALL have parameter OUTSTANDING_DEPTH, default 2, maximum granted-but-unanswered transactions.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 m0_req_i/m0_we_i in 1, m0_addr_i/m0_wdata_i in 32, m0_be_i in 4: master 0 (core data) OBI request.
REQ-007 m0_gnt_o/m0_rvalid_o/m0_err_o out 1, m0_rdata_o out 32: master 0 OBI grant/response.
REQ-008 m1_* ports identical to m0_* for master 1 (DMA/debug).
REQ-009 sram_d_req_o/sram_d_we_o out 1, sram_d_addr_o/sram_d_wdata_o out 32, sram_d_be_o out 4: request to SRAM wrapper data port.
REQ-010 sram_d_gnt_i/sram_d_rvalid_i in 1, sram_d_rdata_i in 32: SRAM wrapper grant/response.
REQ-011 illegal_memory_o  out  1  one-cycle pulse when an out-of-range request is granted.

Function
REQ-012 Arbitration SHALL be round-robin: master not granted most recently has priority; at most one grant per cycle.
REQ-013 A request SHALL be eligible only while outstanding count < OUTSTANDING_DEPTH; pop in same cycle does not make a full FIFO eligible.
REQ-014 Winner's addr/we/be/wdata SHALL drive sram_d_* combinationally with sram_d_req_o=1; mN_gnt_o = sram_d_gnt_i for the winner only.
REQ-015 Loser's gnt SHALL be 0; loser request stays pending and wins next eligible cycle.
REQ-016 On each handshake (sram_d_req_o & sram_d_gnt_i) the winner ID with err=0 SHALL be pushed to an in-order ID FIFO.
REQ-017 sram_d_rvalid_i SHALL pop FIFO head and raise that master's rvalid with rdata=sram_d_rdata_i, same cycle (zero added latency).
REQ-018 Non-addressed master SHALL see rvalid=0, rdata=0, err=0.
REQ-019 sram_d_rvalid_i with empty FIFO SHALL be ignored (no master rvalid).
REQ-020 Address legal iff SRAM_BASE_ADDR <= addr < SRAM_END_ADDR (unsigned 32-bit compare).
REQ-021 Illegal request SHALL be granted locally only when FIFO empty, never forwarded (sram_d_req_o=0); illegal_memory_o pulses that cycle.
REQ-022 Illegal request SHALL be answered exactly one cycle after grant: rvalid=1, err=1, rdata=0.
REQ-023 While an error response is pending, no new grant SHALL be issued.
REQ-024 Round-robin pointer SHALL update on every grant, legal or illegal.

Reset
REQ-025 While rst_ni=0 at a clock edge: FIFO emptied, pending error response cleared, round-robin priority to m0.
REQ-026 All outputs SHALL be 0 during and in the first cycle after reset; responses for transactions granted before reset are discarded.

Configuration
REQ-027 With SRAM_ARB_RANGE_CHECK_EN defined: REQ-020..REQ-023 apply.
REQ-028 Without SRAM_ARB_RANGE_CHECK_EN: every request forwarded; err outputs and illegal_memory_o tied 0.

Structure
REQ-029 Package sram_arb_pkg SHALL hold OUTSTANDING_DEPTH default, master-ID typedef (1 bit), FIFO entry struct {id, err}.
REQ-030 Sub-module sram_arb_idfifo (synchronous FIFO, count, full/empty) SHALL hold outstanding IDs.

Verification
REQ-031 m0 and m1 req same cycle after reset, gnt_i=1 -> m0 granted cycle 0, m1 cycle 1; m1 rvalid follows m0 rvalid.
REQ-032 Both held requesting 6 cycles, single-cycle SRAM -> grants alternate m0,m1,m0,...; no master starved.
REQ-033 m0 read 0x8000_0010, rvalid_i with rdata 0xDEADBEEF -> m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
REQ-034 Range check on: m1 addr 0x8000_C000 -> m1_gnt_o=1, illegal_memory_o pulse, sram_d_req_o=0, next cycle m1_rvalid_o=1, m1_err_o=1.
REQ-035 sram_d_rvalid_i held 0 after two grants -> third request not granted until a response pops.
REQ-036 rst_ni low with two outstanding, then rvalid_i -> no master rvalid; next grant goes to m0.
